// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the CPU memory-bus arbiter.
//   - FSM state encoding and round-robin owner tag
//   - line geometry (words per line, default turnaround length)
//   - line-offset mask; keep in step with the cache's maximum word offset
package mem_bus_arbiter_pkg;

  localparam int unsigned LineWords      = 8;
  localparam int unsigned TurnCyclesDflt = 2;

  // 8 words x 4 bytes: byte offset within a line lives in bits [4:0].
  localparam logic [31:0] LineOffsetMask = 32'h0000_001f;

  typedef enum logic [2:0] {
    StIdle,
    StRdI,
    StRdD,
    StWrD,
    StTurn
  } state_e;

  typedef enum logic {
    RrI = 1'b0,
    RrD = 1'b1
  } rr_e;

  function automatic logic [31:0] line_addr(input logic [31:0] addr);
    return addr & ~LineOffsetMask;
  endfunction

endpackage

// File: rtl/mem_beat_counter.sv
// Small up/down counter with clear, load and enable, plus a terminal-count flag.
// Used both as the line beat counter (counting up to the last word) and as the
// bus turnaround countdown (loaded, counting down to zero).
// Ports:
//   CLK, MRST  clock, asynchronous active-high reset (count -> 0)
//   clr        synchronous clear, highest priority
//   load       synchronous load of load_val
//   load_val   value for load
//   en         count one step (up, or down when DOWN=1)
//   tc         count equals TERM
module mem_beat_counter #(
  parameter int unsigned    W    = 3,
  parameter logic [W-1:0]   TERM = '1,
  parameter bit             DOWN = 1'b0
) (
  input  logic         CLK,
  input  logic         MRST,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         tc
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (load) begin
      count_d = load_val;
    end else if (en) begin
      count_d = DOWN ? (count_q - W'(1)) : (count_q + W'(1));
    end
  end

  always_ff @(posedge CLK or posedge MRST) begin
    if (MRST) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc = (count_q == TERM);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbiter sharing the CPU memory bus between the I-cache fill port and the
// D-cache fill/write port. One owner at a time; a fill holds mem_read for the
// whole line burst, a write takes one cycle; every operation is followed by
// TURN_CYCLES idle cycles before the bus can be granted again.
// Ports:
//   CLK, MRST                     clock, asynchronous active-high reset
//   i_req/i_addr                  I$ fill request and line address
//   i_gnt/i_valid/i_last          I$ grant pulse, beat valid, final beat
//   d_rd_req/d_wr_req/d_addr/d_wdata  D$ fill or single-word write request
//   d_gnt/d_valid/d_last          D$ grant pulse, beat valid, final beat
//   mem_addr/mem_read/mem_write/mem_wdata  bus outputs (mem_write = Bus OE)
//   mem_valid/mem_rdata           bus inputs from memory
//   rdata                         read data broadcast to both caches
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int unsigned LINE_WORDS  = LineWords,
  parameter int unsigned TURN_CYCLES = TurnCyclesDflt,
  parameter int unsigned CNT_W       = 3
) (
  input  logic        CLK,
  input  logic        MRST,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_gnt,
  output logic        i_valid,
  output logic        i_last,
  input  logic        d_rd_req,
  input  logic        d_wr_req,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_valid,
  output logic        d_last,
  output logic [31:0] mem_addr,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_wdata,
  input  logic        mem_valid,
  input  logic [31:0] mem_rdata,
  output logic [31:0] rdata
);

  localparam int unsigned TurnW = (TURN_CYCLES > 1) ? $clog2(TURN_CYCLES) : 1;

  state_e      state_q, state_d;
  rr_e         rr_last_q, rr_last_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        i_gnt_q, i_gnt_d;
  logic        d_gnt_q, d_gnt_d;

  logic in_rd, beat_en, beat_tc, last_beat;
  logic turn_load, turn_en, turn_tc;

  assign in_rd     = (state_q == StRdI) || (state_q == StRdD);
  assign beat_en   = in_rd & mem_valid;
  assign last_beat = beat_en & beat_tc;
  // Load the countdown on the cycle we enter TURN, count it down while in it.
  assign turn_load = (state_d == StTurn) && (state_q != StTurn);
  assign turn_en   = (state_q == StTurn);

  mem_beat_counter #(
    .W    (CNT_W),
    .TERM (CNT_W'(LINE_WORDS - 1)),
    .DOWN (1'b0)
  ) u_beat_cnt (
    .CLK      (CLK),
    .MRST     (MRST),
    .clr      (last_beat),
    .load     (1'b0),
    .load_val ('0),
    .en       (beat_en),
    .tc       (beat_tc)
  );

  mem_beat_counter #(
    .W    (TurnW),
    .TERM ('0),
    .DOWN (1'b1)
  ) u_turn_cnt (
    .CLK      (CLK),
    .MRST     (MRST),
    .clr      (1'b0),
    .load     (turn_load),
    .load_val (TurnW'(TURN_CYCLES - 1)),
    .en       (turn_en),
    .tc       (turn_tc)
  );

  // State register
  always_ff @(posedge CLK or posedge MRST) begin
    if (MRST) begin
      state_q     <= StIdle;
      rr_last_q   <= RrI;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      i_gnt_q     <= 1'b0;
      d_gnt_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_last_q   <= rr_last_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      i_gnt_q     <= i_gnt_d;
      d_gnt_q     <= d_gnt_d;
    end
  end

  // Next-state and arbitration
  always_comb begin
    state_d     = state_q;
    rr_last_d   = rr_last_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    i_gnt_d     = 1'b0;
    d_gnt_d     = 1'b0;
    unique case (state_q)
      StIdle: begin
        // Writes first so write-through data lands before any refill of that line.
        if (d_wr_req) begin
          state_d     = StWrD;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
          d_gnt_d     = 1'b1;
        end else if (i_req && (!d_rd_req || (rr_last_q == RrD))) begin
          state_d    = StRdI;
          mem_addr_d = line_addr(i_addr);
          i_gnt_d    = 1'b1;
        end else if (d_rd_req) begin
          state_d    = StRdD;
          mem_addr_d = line_addr(d_addr);
          d_gnt_d    = 1'b1;
        end
      end
      StRdI, StRdD: begin
        if (last_beat) begin
          state_d   = StTurn;
          rr_last_d = (state_q == StRdI) ? RrI : RrD;
        end
      end
      StWrD: state_d = StTurn;
      StTurn: begin
        if (turn_tc) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs
  always_comb begin
    mem_read  = in_rd;
    mem_write = (state_q == StWrD);
    i_valid   = mem_valid & (state_q == StRdI);
    d_valid   = mem_valid & (state_q == StRdD);
    i_last    = i_valid & beat_tc;
    d_last    = d_valid & beat_tc;
  end

  assign i_gnt     = i_gnt_q;
  assign d_gnt     = d_gnt_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign rdata     = mem_rdata;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
module tb_mem_bus_arbiter;

  localparam int LW = 8;
  localparam int TC = 2;
  localparam int OwnNone = 0, OwnI = 1, OwnD = 2, OwnW = 3;

  logic        CLK = 1'b0;
  logic        MRST;
  logic        i_req, d_rd_req, d_wr_req, mem_valid;
  logic [31:0] i_addr, d_addr, d_wdata, mem_rdata;
  logic        i_gnt, i_valid, i_last, d_gnt, d_valid, d_last;
  logic        mem_read, mem_write;
  logic [31:0] mem_addr, mem_wdata, rdata;

  mem_bus_arbiter dut (
    .CLK       (CLK),
    .MRST      (MRST),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .i_gnt     (i_gnt),
    .i_valid   (i_valid),
    .i_last    (i_last),
    .d_rd_req  (d_rd_req),
    .d_wr_req  (d_wr_req),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_gnt     (d_gnt),
    .d_valid   (d_valid),
    .d_last    (d_last),
    .mem_addr  (mem_addr),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_wdata (mem_wdata),
    .mem_valid (mem_valid),
    .mem_rdata (mem_rdata),
    .rdata     (rdata)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: who owns the bus, beats received, turnaround left.
  int          m_owner, m_beats, m_turn, m_rr;
  bit          m_gnt;
  logic [31:0] m_addr, m_wdata;

  // Memory/requester agent knobs and observation counters.
  int          vprob, stray_prob, beat_idx, cyc;
  logic [31:0] data_base;
  bit          i_hold;
  bit          saw_ilast, saw_dlast, saw_dwgnt, prev_read;
  int          ev_ival, ev_dval, ev_ilast, ev_dlast, ev_ig, ev_dg, first_gnt;
  int          last_cyc, rise_cyc, wr_cyc, saved_last;
  logic [31:0] last_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = OwnNone; m_beats = 0; m_turn = 0; m_rr = OwnI; m_gnt = 0;
    m_addr = '0; m_wdata = '0;
  endtask

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic model_edge();
    int pick;
    m_gnt = 0;
    if (MRST) begin
      model_reset();
    end else if (m_turn > 0) begin
      m_turn--;
    end else if (m_owner == OwnNone) begin
      if (d_wr_req) begin
        m_owner = OwnW; m_addr = d_addr; m_wdata = d_wdata; m_gnt = 1;
      end else if (i_req || d_rd_req) begin
        if (i_req && d_rd_req) pick = (m_rr == OwnI) ? OwnD : OwnI;
        else pick = i_req ? OwnI : OwnD;
        m_owner = pick;
        m_addr  = ((pick == OwnI) ? i_addr : d_addr) & 32'hffff_ffe0;
        m_gnt   = 1;
        m_beats = 0;
      end
    end else if (m_owner == OwnW) begin
      m_owner = OwnNone; m_turn = TC;
    end else if (mem_valid) begin
      m_beats++;
      if (m_beats == LW) begin
        m_rr = m_owner; m_owner = OwnNone; m_turn = TC; m_beats = 0;
      end
    end
  endtask

  task automatic check_outputs();
    bit e_read, e_write, e_iv, e_dv;
    e_read  = (m_owner == OwnI) || (m_owner == OwnD);
    e_write = (m_owner == OwnW);
    e_iv    = mem_valid && (m_owner == OwnI);
    e_dv    = mem_valid && (m_owner == OwnD);
    chk("mem_read", 32'(mem_read), 32'(e_read));
    chk("mem_write", 32'(mem_write), 32'(e_write));
    chk("i_valid", 32'(i_valid), 32'(e_iv));
    chk("d_valid", 32'(d_valid), 32'(e_dv));
    chk("i_last", 32'(i_last), 32'(e_iv && (m_beats == LW - 1)));
    chk("d_last", 32'(d_last), 32'(e_dv && (m_beats == LW - 1)));
    chk("i_gnt", 32'(i_gnt), 32'(m_gnt && (m_owner == OwnI)));
    chk("d_gnt", 32'(d_gnt), 32'(m_gnt && (m_owner == OwnD || m_owner == OwnW)));
    chk("mem_addr", mem_addr, m_addr);
    if (e_write) chk("mem_wdata", mem_wdata, m_wdata);
    chk("rdata", rdata, mem_rdata);
  endtask

  // One clock: check, edge, model step, then agents drive new inputs at negedge.
  task automatic cycle();
    #1;
    check_outputs();
    saw_ilast = i_last; saw_dlast = d_last; saw_dwgnt = d_gnt && mem_write;
    if (i_valid) ev_ival++;
    if (d_valid) ev_dval++;
    if (i_last) begin ev_ilast++; last_data = rdata; last_cyc = cyc; end
    if (d_last) begin ev_dlast++; last_data = rdata; last_cyc = cyc; end
    if (i_gnt) begin ev_ig++; if (first_gnt == 0) first_gnt = OwnI; end
    if (d_gnt) begin ev_dg++; if (first_gnt == 0) first_gnt = mem_write ? OwnW : OwnD; end
    if (mem_write) wr_cyc = cyc;
    if (mem_read && !prev_read) rise_cyc = cyc;
    prev_read = mem_read;
    cyc++;
    @(posedge CLK);
    model_edge();
    @(negedge CLK);
    if (saw_ilast && !i_hold) i_req = 1'b0;
    if (saw_dlast) d_rd_req = 1'b0;
    if (saw_dwgnt) d_wr_req = 1'b0;
    if (mem_read) begin
      mem_valid = ($urandom_range(0, 99) < vprob);
    end else begin
      beat_idx  = 0;
      mem_valid = ($urandom_range(0, 99) < stray_prob);
    end
    mem_rdata = (mem_valid && mem_read) ? data_base + 32'(beat_idx) : $urandom;
    if (mem_valid && mem_read) beat_idx++;
  endtask

  task automatic clear_ev();
    ev_ival = 0; ev_dval = 0; ev_ilast = 0; ev_dlast = 0; ev_ig = 0; ev_dg = 0;
    first_gnt = 0;
  endtask

  task automatic run_until_last(input bit is_d, input int budget);
    bit done = 0;
    for (int k = 0; k < budget && !done; k++) begin
      cycle();
      done = is_d ? saw_dlast : saw_ilast;
    end
    chk(is_d ? "d_last_timeout" : "i_last_timeout", 32'(done), 32'd1);
  endtask

  task automatic run_cycles(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  task automatic pulse_reset();
    MRST = 1'b1;
    model_reset();
    run_cycles(2);
    MRST = 1'b0;
  endtask

  initial begin
    MRST = 1'b1; i_req = 0; d_rd_req = 0; d_wr_req = 0; mem_valid = 0;
    i_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = 32'h1234_5678;
    vprob = 100; stray_prob = 0; data_base = 32'h100; beat_idx = 0; i_hold = 0;
    cyc = 0; prev_read = 0; last_cyc = 0; rise_cyc = 0; wr_cyc = 0; last_data = '0;
    model_reset();
    clear_ev();
    @(negedge CLK);
    run_cycles(2);
    MRST = 1'b0;
    run_cycles(2);

    // Single I$ fill.
    clear_ev();
    i_req = 1; i_addr = 32'h0040_0014;
    cycle();
    #1;
    chk("ifill_gnt", 32'(i_gnt), 32'd1);
    chk("ifill_addr", mem_addr, 32'h0040_0000);
    run_until_last(0, 20);
    chk("ifill_ival_cnt", 32'(ev_ival), 32'd8);
    chk("ifill_ilast_cnt", 32'(ev_ilast), 32'd1);
    chk("ifill_last_data", last_data, 32'h107);
    chk("ifill_dval_cnt", 32'(ev_dval), 32'd0);
    run_cycles(4);

    // Collision right after reset: D first, then I, then D again.
    pulse_reset();
    clear_ev();
    i_req = 1; i_addr = 32'h0050_0000; d_rd_req = 1; d_addr = 32'h0060_0020;
    data_base = 32'h200;
    run_until_last(1, 30);
    chk("coll_first_d", 32'(first_gnt), 32'(OwnD));
    chk("coll_no_i_yet", 32'(ev_ig), 32'd0);
    clear_ev();
    run_until_last(0, 30);
    chk("coll_then_i", 32'(first_gnt), 32'(OwnI));
    clear_ev();
    i_req = 1; d_rd_req = 1;
    run_until_last(1, 30);
    chk("coll_again_d", 32'(first_gnt), 32'(OwnD));
    run_until_last(0, 30);
    run_cycles(4);

    // Write priority over a simultaneous I$ fill.
    clear_ev();
    d_wr_req = 1; d_addr = 32'h1000_0008; d_wdata = 32'hDEAD_BEEF;
    i_req = 1; i_addr = 32'h0070_0000;
    cycle();
    #1;
    chk("wr_mem_write", 32'(mem_write), 32'd1);
    chk("wr_addr", mem_addr, 32'h1000_0008);
    chk("wr_wdata", mem_wdata, 32'hDEAD_BEEF);
    run_until_last(0, 30);
    chk("wr_first", 32'(first_gnt), 32'(OwnW));
    chk("wr_then_i", 32'(ev_ig), 32'd1);
    chk("wr_to_ifill_gap", 32'(rise_cyc - wr_cyc), 32'(TC + 2));
    run_cycles(4);

    // Valid pulses while idle are ignored.
    clear_ev();
    stray_prob = 100;
    run_cycles(5);
    stray_prob = 0;
    chk("idle_valid_i", 32'(ev_ival), 32'd0);
    chk("idle_valid_d", 32'(ev_dval), 32'd0);
    chk("idle_valid_gnt", 32'(ev_ig + ev_dg), 32'd0);

    // Reset in the middle of a D$ fill.
    clear_ev();
    d_rd_req = 1; d_addr = 32'h3000_0040; data_base = 32'h300;
    for (int k = 0; k < 30 && ev_dval < 3; k++) cycle();
    chk("mid_three_beats", 32'(ev_dval), 32'd3);
    MRST = 1'b1;
    model_reset();
    d_rd_req = 0;
    #1;
    chk("mid_rst_read", 32'(mem_read), 32'd0);
    run_cycles(2);
    MRST = 1'b0;
    run_cycles(1);
    clear_ev();
    d_rd_req = 1;
    run_until_last(1, 30);
    chk("mid_refill_beats", 32'(ev_dval), 32'd8);
    chk("mid_refill_last", 32'(ev_dlast), 32'd1);
    chk("mid_refill_data", last_data, 32'h307);
    run_cycles(4);

    // Back-to-back I$ fills with i_req held continuously.
    vprob = 60;
    i_hold = 1; i_req = 1; i_addr = 32'h0080_0000;
    run_until_last(0, 60);
    saved_last = last_cyc;
    run_until_last(0, 60);
    chk("b2b_gap", 32'(rise_cyc - saved_last), 32'(TC + 2));
    i_hold = 0;
    run_until_last(0, 60);
    run_cycles(4);

    // Randomised traffic against the model.
    vprob = 70; stray_prob = 15;
    for (int k = 0; k < 1500; k++) begin
      cycle();
      if (!i_req && $urandom_range(0, 3) == 0) begin
        i_req = 1; i_addr = $urandom;
      end
      if (!d_rd_req && !d_wr_req) begin
        int r;
        r = $urandom_range(0, 7);
        if (r == 0) begin
          d_wr_req = 1; d_addr = $urandom; d_wdata = $urandom;
        end else if (r < 3) begin
          d_rd_req = 1; d_addr = $urandom;
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
